// File: rtl/alu_mux_pkg.sv
// Shared helpers and pipeline-stage type for the N:1 pipelined ALU result mux.
`ifndef ALU_MUX_STAGE_T
`define ALU_MUX_STAGE_T(W) struct packed { logic v; logic err; logic [(W)-1:0] d; }
`endif

package alu_mux_pkg;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fill value for beats whose select addresses no channel.
    localparam logic MUX_ERR_DATA = '0;

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipeline register of the result mux: holds {v, err, d} and chains ready upstream.
`ifndef ALU_MUX_STAGE_T
`define ALU_MUX_STAGE_T(W) struct packed { logic v; logic err; logic [(W)-1:0] d; }
`endif

module mux_pipe_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clkpos,
    input  logic             rst,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic             up_err_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             dn_valid_o,
    input  logic             dn_ready_i,
    output logic             dn_err_o,
    output logic [WIDTH-1:0] dn_data_o
);

    typedef `ALU_MUX_STAGE_T(WIDTH) stage_t;

    stage_t stage_q;
    stage_t stage_d;
    logic   load;

    // An empty stage always accepts, so bubbles collapse even while downstream stalls.
    assign up_ready_o = !stage_q.v || dn_ready_i;
    assign load       = up_valid_i && up_ready_o;

    // NOTE: stage_d starts as a copy of stage_q so every path assigns it (no latch),
    // and the register below takes it with <= so all stages update on the same edge.
    always_comb begin
        stage_d = stage_q;
        if (load) begin
            stage_d.v   = 1'b1;
            stage_d.err = up_err_i;
            stage_d.d   = up_data_i;
        end else if (dn_ready_i) begin
            stage_d.v = 1'b0;
        end
    end

    always_ff @(posedge clkpos or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dn_valid_o = stage_q.v;
    assign dn_err_o   = stage_q.err;
    assign dn_data_o  = stage_q.d;

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-input select-and-forward pipeline with valid/ready flow control and bad-select flagging.
module mux_nto1_pipe
    import alu_mux_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 3,
    parameter  int STAGES = 2,
    localparam int SEL_W  = sel_w(NUM_IN)
) (
    input  logic                    clkpos,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    always_comb begin
        sel_data = {WIDTH{MUX_ERR_DATA}};
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(in_sel) == k) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    // Index i is the link feeding stage i; index STAGES is the output port.
    logic             v_w   [STAGES+1];
    logic             rdy_w [STAGES+1];
    logic             err_w [STAGES+1];
    logic [WIDTH-1:0] d_w   [STAGES+1];

    assign v_w[0]        = in_valid;
    assign err_w[0]      = sel_err;
    assign d_w[0]        = sel_data;
    assign rdy_w[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mux_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clkpos     (clkpos),
            .rst        (rst),
            .up_valid_i (v_w[i]),
            .up_ready_o (rdy_w[i]),
            .up_err_i   (err_w[i]),
            .up_data_i  (d_w[i]),
            .dn_valid_o (v_w[i+1]),
            .dn_ready_i (rdy_w[i+1]),
            .dn_err_o   (err_w[i+1]),
            .dn_data_o  (d_w[i+1])
        );
    end

    // Refuse beats while reset is held, even though the stages themselves look empty.
    assign in_ready  = rdy_w[0] && !rst;
    assign out_valid = v_w[STAGES];
    assign out_err   = err_w[STAGES];
    assign out_data  = d_w[STAGES];

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed, table-driven bench for mux_nto1_pipe plus a small parameter sweep.
module tb_mux_nto1_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration: WIDTH=16, NUM_IN=3, STAGES=2
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [1:0]  a_in_sel   = '0;
    logic [47:0] a_in_data  = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [15:0] a_out_data;
    logic        a_out_err;

    mux_nto1_pipe dut_a (
        .clkpos(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sel(a_in_sel), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
    );

    // WIDTH=8, NUM_IN=5, STAGES=1
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [2:0]  b_in_sel   = '0;
    logic [39:0] b_in_data  = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_out_data;
    logic        b_out_err;

    mux_nto1_pipe #(.WIDTH(8), .NUM_IN(5), .STAGES(1)) dut_b (
        .clkpos(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
    );

    // WIDTH=32, NUM_IN=2, STAGES=4
    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [0:0]  c_in_sel   = '0;
    logic [63:0] c_in_data  = '0;
    logic        c_out_valid;
    logic        c_out_ready = 1'b1;
    logic [31:0] c_out_data;
    logic        c_out_err;

    mux_nto1_pipe #(.WIDTH(32), .NUM_IN(2), .STAGES(4)) dut_c (
        .clkpos(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sel(c_in_sel), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel,
                           input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        a_in_valid = v;
        a_in_sel   = sel;
        a_in_data  = {c2, c1, c0};
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] ch0;
        logic [15:0] ch1;
        logic [15:0] ch2;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    localparam int NVEC  = 7;
    localparam int NSWP  = 10;

    vec_t        vecs [NVEC];
    logic [7:0]  b_exp_d [NSWP];
    logic        b_exp_e [NSWP];
    logic [31:0] c_exp_d [NSWP];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd0, 16'h1111, 16'h2222, 16'h3333, 16'h1111, 1'b0};
        vecs[1] = '{2'd1, 16'h1111, 16'h2222, 16'h3333, 16'h2222, 1'b0};
        vecs[2] = '{2'd2, 16'h1111, 16'h2222, 16'h3333, 16'h3333, 1'b0};
        vecs[3] = '{2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
        vecs[4] = '{2'd2, 16'hABCD, 16'h5A5A, 16'h0F0F, 16'h0F0F, 1'b0};
        vecs[5] = '{2'd0, 16'hABCD, 16'h5A5A, 16'h0F0F, 16'hABCD, 1'b0};
        vecs[6] = '{2'd1, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0};

        // Reset state, then release away from the clock edge
        #12;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data",  64'(a_out_data),  64'd0);
        check("rst_out_err",   64'(a_out_err),   64'd0);
        check("rst_in_ready",  64'(a_in_ready),  64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        tick();

        // Streaming with out_ready held high: vector i appears two edges after it is driven
        a_out_ready = 1'b1;
        for (int i = 0; i <= NVEC; i++) begin
            if (i < NVEC) drive_a(1'b1, vecs[i].sel, vecs[i].ch0, vecs[i].ch1, vecs[i].ch2);
            else          drive_a(1'b0, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            #1;
            check($sformatf("stream_in_ready[%0d]", i), 64'(a_in_ready), 64'd1);
            tick();
            if (i == 0) begin
                check("stream_latency_empty", 64'(a_out_valid), 64'd0);
            end else begin
                check($sformatf("stream_valid[%0d]", i-1), 64'(a_out_valid), 64'd1);
                check($sformatf("stream_data[%0d]",  i-1), 64'(a_out_data),  64'(vecs[i-1].exp_d));
                check($sformatf("stream_err[%0d]",   i-1), 64'(a_out_err),   64'(vecs[i-1].exp_e));
            end
        end
        tick();
        check("stream_drained", 64'(a_out_valid), 64'd0);

        // Asynchronous reset with two beats in flight
        a_out_ready = 1'b0;
        drive_a(1'b1, 2'd0, 16'hAAAA, 16'h0000, 16'h0000);
        tick();
        drive_a(1'b1, 2'd1, 16'h0000, 16'hBBBB, 16'h0000);
        tick();
        drive_a(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000);
        check("midrst_pre_valid", 64'(a_out_valid), 64'd1);
        check("midrst_pre_data",  64'(a_out_data),  64'hAAAA);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid",    64'(a_out_valid), 64'd0);
        check("midrst_data",     64'(a_out_data),  64'd0);
        check("midrst_in_ready", 64'(a_in_ready),  64'd0);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", 64'(a_in_ready),  64'd1);
        check("midrst_release_valid",    64'(a_out_valid), 64'd0);
        a_out_ready = 1'b1;
        drive_a(1'b1, 2'd2, 16'h0000, 16'h0000, 16'hC0C0);
        tick();
        drive_a(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000);
        check("midrst_no_ghost", 64'(a_out_valid), 64'd0);
        tick();
        check("midrst_first_valid", 64'(a_out_valid), 64'd1);
        check("midrst_first_data",  64'(a_out_data),  64'hC0C0);
        tick();
        check("midrst_empty", 64'(a_out_valid), 64'd0);

        // Backpressure: two beats fill the pipe, the third is refused
        a_out_ready = 1'b0;
        drive_a(1'b1, 2'd1, 16'h0A0A, 16'hA001, 16'h0B0B);
        #1;
        check("bp_acc0", 64'(a_in_ready), 64'd1);
        tick();
        drive_a(1'b1, 2'd2, 16'h0A0A, 16'h0B0B, 16'hB002);
        #1;
        check("bp_acc1", 64'(a_in_ready), 64'd1);
        tick();
        drive_a(1'b1, 2'd3, 16'h1234, 16'h5678, 16'h9ABC);
        #1;
        check("bp_full_in_ready", 64'(a_in_ready), 64'd0);
        check("bp_head_data",     64'(a_out_data), 64'hA001);
        tick();
        check("bp_hold_valid",    64'(a_out_valid), 64'd1);
        check("bp_hold_data",     64'(a_out_data),  64'hA001);
        check("bp_hold_err",      64'(a_out_err),   64'd0);
        check("bp_hold_in_ready", 64'(a_in_ready),  64'd0);

        // Same-cycle pop and push on a full pipe
        a_out_ready = 1'b1;
        #1;
        check("simul_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        drive_a(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000);
        a_out_ready = 1'b0;
        #1;
        check("simul_occupancy_full", 64'(a_in_ready), 64'd0);
        check("simul_data_b",         64'(a_out_data), 64'hB002);
        a_out_ready = 1'b1;
        tick();
        check("drain_c_valid", 64'(a_out_valid), 64'd1);
        check("drain_c_data",  64'(a_out_data),  64'h0000);
        check("drain_c_err",   64'(a_out_err),   64'd1);
        tick();
        check("drain_empty", 64'(a_out_valid), 64'd0);

        // Parameter sweep on the two alternate configurations
        for (int i = 0; i < NSWP; i++) begin
            int sb;
            sb = i % 8;
            b_exp_d[i] = (sb < 5) ? 8'(i*16 + sb + 1) : 8'h00;
            b_exp_e[i] = (sb >= 5);
            c_exp_d[i] = 32'hC0DE0000 + 32'(i*256) + 32'(i % 2);
        end
        for (int i = 0; i < NSWP + 4; i++) begin
            if (i < NSWP) begin
                b_in_valid = 1'b1;
                b_in_sel   = 3'(i % 8);
                for (int k = 0; k < 5; k++) b_in_data[k*8 +: 8] = 8'(i*16 + k + 1);
                c_in_valid = 1'b1;
                c_in_sel   = 1'(i % 2);
                for (int k = 0; k < 2; k++) c_in_data[k*32 +: 32] = 32'hC0DE0000 + 32'(i*256) + 32'(k);
            end else begin
                b_in_valid = 1'b0;
                b_in_sel   = 3'd7;
                b_in_data  = '1;
                c_in_valid = 1'b0;
                c_in_data  = '1;
            end
            tick();
            if (i < NSWP) begin
                check($sformatf("swp_b_valid[%0d]", i), 64'(b_out_valid), 64'd1);
                check($sformatf("swp_b_data[%0d]",  i), 64'(b_out_data),  64'(b_exp_d[i]));
                check($sformatf("swp_b_err[%0d]",   i), 64'(b_out_err),   64'(b_exp_e[i]));
            end else begin
                check($sformatf("swp_b_idle[%0d]", i), 64'(b_out_valid), 64'd0);
            end
            if (i < 3 || i - 3 >= NSWP) begin
                check($sformatf("swp_c_idle[%0d]", i), 64'(c_out_valid), 64'd0);
            end else begin
                check($sformatf("swp_c_valid[%0d]", i-3), 64'(c_out_valid), 64'd1);
                check($sformatf("swp_c_data[%0d]",  i-3), 64'(c_out_data),  64'(c_exp_d[i-3]));
                check($sformatf("swp_c_err[%0d]",   i-3), 64'(c_out_err),   64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
